// File: rtl/instr_fetch.sv
// Purpose: instruction fetch stage feeding the control unit; PC, single-outstanding imem requests, 1-entry skid.
// Latency: response lands in if_instr on the edge imem_valid is sampled; one instruction per 2 cycles with 1-cycle memory.
// Backpressure: stall holds if_valid/if_instr/if_pc; a response arriving under stall parks in the skid and fetch pauses.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_req/imem_addr    request strobe (FETCH only) and address (= pc)
//   imem_rdata/imem_valid one-cycle response pulse, at most one outstanding
//   stall                 downstream cannot accept the presented instruction
//   redirect_valid/_pc    taken branch/jump from execute
//   if_valid/if_instr/if_pc  registered instruction and its address
//   con_opcode, op1, op2, funct, imm8, jmp_off  field slices of if_instr
//   halted                HALT (opcode 0000) fetched, fetching stopped
module instr_fetch #(
  parameter int unsigned            PC_WIDTH    = 16,
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [3:0]             con_opcode,
  output logic [3:0]             op1,
  output logic [3:0]             op2,
  output logic [3:0]             funct,
  output logic [7:0]             imm8,
  output logic [11:0]            jmp_off,
  output logic                   halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]    skid_pc;

  logic slot_free;
  logic rsp_halt;
  logic skid_halt;

  // The output register can take new data if it is empty or being consumed this edge.
  assign slot_free = !if_valid || !stall;
  assign rsp_halt  = (imem_rdata[INSTR_WIDTH-1 -: 4] == 4'h0);
  assign skid_halt = (skid_instr[INSTR_WIDTH-1 -: 4] == 4'h0);

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  assign con_opcode = if_instr[INSTR_WIDTH-1 -: 4];
  assign op1        = if_instr[11:8];
  assign op2        = if_instr[7:4];
  assign funct      = if_instr[3:0];
  assign imm8       = if_instr[7:0];
  assign jmp_off    = if_instr[11:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      halted     <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and discards the presented instruction and
      // any skid contents (leaving HOLD makes the skid dead). If a request is
      // still in flight its response must be swallowed in DRAIN; a response
      // arriving on this very edge is simply dropped.
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      halted   <= 1'b0;
      if (((state == S_WAIT) || (state == S_DRAIN)) && !imem_valid) begin
        state <= S_DRAIN;
      end else begin
        state <= S_FETCH;
      end
    end else begin
      // Consumption; overridden below when new data is loaded on the same edge.
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end

      case (state)
        S_FETCH: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_valid) begin
            pc <= pc + PC_WIDTH'(2);
            if (slot_free) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              if (rsp_halt) begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (slot_free) begin
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            if_valid <= 1'b1;
            if (skid_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_DRAIN: begin
          if (imem_valid) begin
            state <= S_FETCH;
          end
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
